count29_monitor: RTL and testbench
==================================

# count29_monitor

Receive-side checker for the bouncing 0..MAX up/down counter. Samples the counter's value, mode and sync-reset lines every enabled cycle, predicts the next value from the counter's next-state rule, and flags any deviation. Reports direction, turnarounds and error statistics. It sits beside the counter on the same clock and feeds status LEDs and the test harness.

## Interface
- MAX, 29, top value of the counter's range
- WIDTH, 8, width of the count value
- TCW, 16, width of the turn counter

- clk  in  1  rising-edge clock, shared with the counter
- rst_n  in  1  asynchronous active-low reset
- en  in  1  sample-valid; when high, q_in, mode_in and cnt_rst_in are consumed this cycle
- q_in  in  WIDTH  counter value observed this cycle
- mode_in  in  1  counter mode applied this cycle: 0 = count up, 1 = count down
- cnt_rst_in  in  1  the counter's synchronous reset, as applied this cycle
- clr_err  in  1  clears err, err_code and err_cnt
- match  out  1  one-cycle pulse: the sample equalled the prediction
- err  out  1  sticky error flag
- err_code  out  2  first error since clear: 00 none, 01 STEP mismatch, 10 RANGE (q_in > MAX)
- err_cnt  out  8  number of erroneous samples, saturating at 255
- dir  out  1  direction of the last legal step: 0 = up, 1 = down
- turn  out  1  one-cycle pulse: the last legal step reversed dir
- turn_cnt  out  TCW  number of turns, wraps modulo 2^TCW
- locked  out  1  high while state is TRACK

## Operation
- States: ACQ (no history), TRACK (history valid), FAULT (last sample bad).
- History registers: prev_q, prev_mode, prev_rst. Every accepted sample loads them.
- Prediction, computed from history: prev_rst=1 gives 0. Otherwise, mode 0 gives prev_q==MAX ? MAX-1 : prev_q+1. Mode 1 gives prev_q==0 ? 1 : prev_q-1. All arithmetic is WIDTH bits wide.
- ACQ, en=1: load history and go to TRACK. No match or error is issued.
- TRACK, en=1:
  - If q_in > MAX: RANGE error.
  - Else if q_in differs from the prediction: STEP error.
  - Else: match pulse. The step is +1 or −1, which sets dir. A reversal relative to the previous legal step pulses turn and increments turn_cnt.
  - A step into 0 caused by prev_rst is legal, but it never updates dir or turn.
- On any error: go to FAULT. err is set. err_code latches only if it is currently 00. err_cnt increments.
- FAULT, en=1: the sample re-seeds history and the state returns to TRACK. No check is made on this sample, except that q_in > MAX counts as another RANGE error and the state stays in FAULT.
- en=0 in any state: go to ACQ, because history is broken. dir, turn_cnt and the error outputs are held.
- clr_err together with a new error in the same cycle: the new error wins. err=1, err_code is the new code, err_cnt=1.
- After an ACQ or FAULT re-seed, the first legal step sets dir without pulsing turn.

## Timing
- All outputs are registered and appear on the clk edge after the sample edge, so latency is 1 cycle.
- match and turn are high for exactly one cycle for each qualifying sample.
- The sample following an ACQ entry produces no output pulse. Checking resumes on the second consecutive en cycle.
- Asynchronous reset: state=ACQ. match, err, err_code, err_cnt, dir, turn, turn_cnt and locked are all 0. History registers are 0. Reset mid-stream discards history immediately.
- Back-to-back errors each increment err_cnt, which holds at 255.

## Structure
- Package count29_pkg holds:
  - the state enum (ACQ, TRACK, FAULT);
  - the err_code constants (ERR_NONE, ERR_STEP, ERR_RANGE);
  - the default MAX.
- Sub-module count29_next: a purely combinational predictor. Inputs are prev_q, prev_mode and prev_rst. Output is the predicted value. It mirrors the counter's next-state rule exactly and is reusable by the counter's own bench.
- Top level: FSM, history registers, error and turn bookkeeping.

## Test plan
- Reset, then a legal up-count 0..29 followed by mode held at 0 (29→28→29). Required: locked=1 from the 2nd sample. match pulses every cycle after the first sample. turn pulses at 29→28 and at 28→29. turn_cnt=2. err=0.
- Legal down-count with mode=1 from 5 to 0, then to 1. Required: dir=1 during the descent. Turn at 0→1. dir=0 afterwards.
- Inject q_in=17 where 13 is expected. Required: err=1, err_code=01, err_cnt=1, no match pulse. The next sample re-seeds and the state returns to TRACK. The following legal sample pulses match.
- Inject q_in=40. Required: err_code=10 and the state stays in FAULT. A later STEP error leaves err_code at 10 and err_cnt=2. clr_err returns all three outputs to 0.
- cnt_rst_in=1 at q=12, then q_in=0. Required: match pulses, with no turn and no error. Drop en for one cycle. Required: locked=0, and the next sample produces no pulse.
- Assert clr_err in the same cycle as a STEP error. Required: err=1, err_code=01, err_cnt=1. Assert rst_n low mid-stream. Required: all outputs are 0 immediately, without waiting for a clk edge.

Source files
------------

// File: rtl/count29_pkg.sv
// Shared types and constants for the count29 receive-side monitor.
// Holds the monitor state encoding, error codes and default geometry.
package count29_pkg;

    typedef enum logic [1:0] {
        ACQ   = 2'd0,
        TRACK = 2'd1,
        FAULT = 2'd2
    } state_t;

    localparam logic [1:0] ERR_NONE  = 2'b00;
    localparam logic [1:0] ERR_STEP  = 2'b01;
    localparam logic [1:0] ERR_RANGE = 2'b10;

    localparam int DEFAULT_MAX   = 29;
    localparam int DEFAULT_WIDTH = 8;
    localparam int DEFAULT_TCW   = 16;

endpackage

// File: rtl/count29_if.sv
// Sample and status bus between the counter harness and count29_monitor.
// The master side drives samples and clr_err; the slave side is the monitor.
interface count29_if
    import count29_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int TCW   = DEFAULT_TCW
) ();

    logic             en;
    logic [WIDTH-1:0] q_in;
    logic             mode_in;
    logic             cnt_rst_in;
    logic             clr_err;

    logic             match;
    logic             err;
    logic [1:0]       err_code;
    logic [7:0]       err_cnt;
    logic             dir;
    logic             turn;
    logic [TCW-1:0]   turn_cnt;
    logic             locked;

    modport master (
        output en, q_in, mode_in, cnt_rst_in, clr_err,
        input  match, err, err_code, err_cnt, dir, turn, turn_cnt, locked
    );

    modport slave (
        input  en, q_in, mode_in, cnt_rst_in, clr_err,
        output match, err, err_code, err_cnt, dir, turn, turn_cnt, locked
    );

endinterface

// File: rtl/count29_next.sv
// Combinational next-state rule of the bouncing 0..MAX counter.
// Kept standalone so the counter's own bench can reuse the same predictor.
module count29_next
    import count29_pkg::*;
#(
    parameter int MAX   = DEFAULT_MAX,
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic [WIDTH-1:0] prev_q,
    input  logic             prev_mode,
    input  logic             prev_rst,
    output logic [WIDTH-1:0] pred
);

    localparam logic [WIDTH-1:0] MAX_W = WIDTH'(MAX);
    localparam logic [WIDTH-1:0] ONE_W = WIDTH'(1);

    // The counter bounces at both ends instead of wrapping.
    always_comb begin
        pred = '0;
        if (prev_rst) begin
            pred = '0;
        end else if (!prev_mode) begin
            pred = (prev_q == MAX_W) ? (MAX_W - ONE_W) : (prev_q + ONE_W);
        end else begin
            pred = (prev_q == '0) ? ONE_W : (prev_q - ONE_W);
        end
    end

endmodule

// File: rtl/count29_monitor.sv
// Checks every enabled sample of the bouncing counter against its predicted
// next value and keeps direction, turn and error statistics.
module count29_monitor
    import count29_pkg::*;
#(
    parameter int MAX   = DEFAULT_MAX,
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int TCW   = DEFAULT_TCW
) (
    input logic      clk,
    input logic      rst_n,
    count29_if.slave bus
);

    localparam logic [WIDTH-1:0] MAX_W = WIDTH'(MAX);
    localparam logic [WIDTH-1:0] ONE_W = WIDTH'(1);

    state_t           state;
    state_t           state_nxt;

    logic [WIDTH-1:0] prev_q;
    logic             prev_mode;
    logic             prev_rst;
    logic [WIDTH-1:0] pred;

    logic             step_valid;
    logic             match_r;
    logic             turn_r;
    logic             err_r;
    logic [1:0]       err_code_r;
    logic [7:0]       err_cnt_r;
    logic             dir_r;
    logic [TCW-1:0]   turn_cnt_r;

    logic             range_bad;
    logic             step_down;
    logic             chk_match;
    logic             chk_step;
    logic             chk_turn;
    logic             chk_err;
    logic [1:0]       chk_code;

    count29_next #(
        .MAX   (MAX),
        .WIDTH (WIDTH)
    ) u_next (
        .prev_q    (prev_q),
        .prev_mode (prev_mode),
        .prev_rst  (prev_rst),
        .pred      (pred)
    );

    assign range_bad = (bus.q_in > MAX_W);
    // A legal non-reset step is either +1 or -1 from the previous value.
    assign step_down = (pred != (prev_q + ONE_W));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ACQ;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (!bus.en) begin
            state_nxt = ACQ;
        end else begin
            case (state)
                ACQ:     state_nxt = TRACK;
                TRACK:   state_nxt = (range_bad || (bus.q_in != pred)) ? FAULT : TRACK;
                FAULT:   state_nxt = range_bad ? FAULT : TRACK;
                default: state_nxt = ACQ;
            endcase
        end
    end

    always_comb begin
        chk_match = 1'b0;
        chk_step  = 1'b0;
        chk_err   = 1'b0;
        chk_code  = ERR_NONE;
        if (bus.en) begin
            case (state)
                TRACK: begin
                    if (range_bad) begin
                        chk_err  = 1'b1;
                        chk_code = ERR_RANGE;
                    end else if (bus.q_in != pred) begin
                        chk_err  = 1'b1;
                        chk_code = ERR_STEP;
                    end else begin
                        chk_match = 1'b1;
                        chk_step  = !prev_rst;
                    end
                end
                FAULT: begin
                    if (range_bad) begin
                        chk_err  = 1'b1;
                        chk_code = ERR_RANGE;
                    end
                end
                default: ;
            endcase
        end
        chk_turn = chk_step && step_valid && (step_down != dir_r);
    end

    // step_valid forgets the last direction whenever history is re-seeded.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_q     <= '0;
            prev_mode  <= 1'b0;
            prev_rst   <= 1'b0;
            step_valid <= 1'b0;
            match_r    <= 1'b0;
            turn_r     <= 1'b0;
            err_r      <= 1'b0;
            err_code_r <= ERR_NONE;
            err_cnt_r  <= '0;
            dir_r      <= 1'b0;
            turn_cnt_r <= '0;
        end else begin
            match_r <= chk_match;
            turn_r  <= chk_turn;
            if (bus.en) begin
                prev_q    <= bus.q_in;
                prev_mode <= bus.mode_in;
                prev_rst  <= bus.cnt_rst_in;
            end
            if (!bus.en || (state != TRACK)) begin
                step_valid <= 1'b0;
            end else if (chk_step) begin
                step_valid <= 1'b1;
            end
            if (chk_step) begin
                dir_r <= step_down;
            end
            if (chk_turn) begin
                turn_cnt_r <= turn_cnt_r + 1'b1;
            end
            // A new error in the same cycle as clr_err starts a fresh record.
            if (chk_err) begin
                err_r <= 1'b1;
                if (bus.clr_err || (err_code_r == ERR_NONE)) begin
                    err_code_r <= chk_code;
                end
                if (bus.clr_err) begin
                    err_cnt_r <= 8'd1;
                end else if (err_cnt_r != 8'hFF) begin
                    err_cnt_r <= err_cnt_r + 8'd1;
                end
            end else if (bus.clr_err) begin
                err_r      <= 1'b0;
                err_code_r <= ERR_NONE;
                err_cnt_r  <= '0;
            end
        end
    end

    assign bus.match    = match_r;
    assign bus.turn     = turn_r;
    assign bus.err      = err_r;
    assign bus.err_code = err_code_r;
    assign bus.err_cnt  = err_cnt_r;
    assign bus.dir      = dir_r;
    assign bus.turn_cnt = turn_cnt_r;
    assign bus.locked   = (state == TRACK);

endmodule

// File: tb/tb_count29_monitor.sv
// Scoreboard bench for count29_monitor: directed scenarios, then random
// samples, all predicted by a behavioural model of the counter checker.
module tb_count29_monitor;

    localparam int MAX = 29;

    typedef struct {
        bit match;
        bit turn;
        bit err;
        bit dir;
        bit locked;
        int code;
        int cnt;
        int tcnt;
    } exp_t;

    logic clk;
    logic rst_n;
    int   total;
    int   bad;
    int   gen_q;

    exp_t exp_q[$];

    bit m_hist;
    bit m_fault;
    bit m_dirk;
    bit m_dir;
    int m_pq;
    bit m_pm;
    bit m_pr;
    bit m_err;
    int m_code;
    int m_cnt;
    int m_tcnt;

    count29_if #(.WIDTH(8), .TCW(16)) bus ();

    count29_monitor #(.MAX(MAX), .WIDTH(8), .TCW(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int nextVal(input int q, input bit mode, input bit crst);
        if (crst) return 0;
        if (!mode) return (q == MAX) ? MAX - 1 : (q + 1) % 256;
        return (q == 0) ? 1 : (q + 255) % 256;
    endfunction

    task automatic checkField(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, act, req, $time);
        end
    endtask

    task automatic checkOutput(input exp_t e);
        checkField("match",    32'(bus.match),    32'(e.match));
        checkField("turn",     32'(bus.turn),     32'(e.turn));
        checkField("err",      32'(bus.err),      32'(e.err));
        checkField("err_code", 32'(bus.err_code), 32'(e.code));
        checkField("err_cnt",  32'(bus.err_cnt),  32'(e.cnt));
        checkField("dir",      32'(bus.dir),      32'(e.dir));
        checkField("turn_cnt", 32'(bus.turn_cnt), 32'(e.tcnt));
        checkField("locked",   32'(bus.locked),   32'(e.locked));
    endtask

    task automatic modelReset();
        m_hist  = 0; m_fault = 0; m_dirk = 0; m_dir = 0;
        m_pq    = 0; m_pm = 0; m_pr = 0;
        m_err   = 0; m_code = 0; m_cnt = 0; m_tcnt = 0;
    endtask

    task automatic modelStep(input bit s_en, input int s_q, input bit s_mode,
                             input bit s_rst, input bit s_clr, output exp_t e);
        bit is_err;
        int new_code;
        int expect_q;
        bit down;
        e.match  = 0;
        e.turn   = 0;
        is_err   = 0;
        new_code = 0;
        if (!s_en) begin
            m_hist = 0; m_fault = 0; m_dirk = 0;
        end else if (!m_hist) begin
            m_hist = 1; m_fault = 0; m_dirk = 0;
        end else if (m_fault) begin
            if (s_q > MAX) begin
                is_err = 1; new_code = 2;
            end else begin
                m_fault = 0; m_dirk = 0;
            end
        end else begin
            expect_q = nextVal(m_pq, m_pm, m_pr);
            if (s_q > MAX) begin
                is_err = 1; new_code = 2; m_fault = 1; m_dirk = 0;
            end else if (s_q != expect_q) begin
                is_err = 1; new_code = 1; m_fault = 1; m_dirk = 0;
            end else begin
                e.match = 1;
                if (!m_pr) begin
                    down = (((s_q - m_pq + 256) % 256) != 1);
                    if (m_dirk && down != m_dir) begin
                        e.turn = 1;
                        m_tcnt = (m_tcnt + 1) % 65536;
                    end
                    m_dir  = down;
                    m_dirk = 1;
                end
            end
        end
        if (s_en) begin
            m_pq = s_q; m_pm = s_mode; m_pr = s_rst;
        end
        if (is_err) begin
            m_err = 1;
            if (s_clr || m_code == 0) m_code = new_code;
            m_cnt = s_clr ? 1 : ((m_cnt < 255) ? m_cnt + 1 : 255);
        end else if (s_clr) begin
            m_err = 0; m_code = 0; m_cnt = 0;
        end
        e.err    = m_err;
        e.code   = m_code;
        e.cnt    = m_cnt;
        e.dir    = m_dir;
        e.tcnt   = m_tcnt;
        e.locked = m_hist && !m_fault;
    endtask

    task automatic applyStimulus(input bit s_en, input int s_q, input bit s_mode,
                                 input bit s_rst, input bit s_clr);
        exp_t e;
        bus.en         = s_en;
        bus.q_in       = 8'(s_q);
        bus.mode_in    = s_mode;
        bus.cnt_rst_in = s_rst;
        bus.clr_err    = s_clr;
        modelStep(s_en, s_q, s_mode, s_rst, s_clr, e);
        @(posedge clk);
        exp_q.push_back(e);
        #1;
    endtask

    task automatic checkResetZero();
        checkField("rst_match",    32'(bus.match),    0);
        checkField("rst_turn",     32'(bus.turn),     0);
        checkField("rst_err",      32'(bus.err),      0);
        checkField("rst_err_code", 32'(bus.err_code), 0);
        checkField("rst_err_cnt",  32'(bus.err_cnt),  0);
        checkField("rst_dir",      32'(bus.dir),      0);
        checkField("rst_turn_cnt", 32'(bus.turn_cnt), 0);
        checkField("rst_locked",   32'(bus.locked),   0);
    endtask

    // Reset lands between edges so the zero outputs must come from the async path.
    task automatic doReset();
        @(negedge clk);
        #1 rst_n = 1'b0;
        #1 checkResetZero();
        modelReset();
        @(negedge clk);
        #1 rst_n = 1'b1;
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) checkOutput(exp_q.pop_front());
    end

    initial begin
        int r;
        int v;
        bit md;
        bit cr;
        bit cl;
        total = 0;
        bad   = 0;
        rst_n = 1'b0;
        bus.en = 1'b0; bus.q_in = '0; bus.mode_in = 1'b0;
        bus.cnt_rst_in = 1'b0; bus.clr_err = 1'b0;
        modelReset();
        #2 checkResetZero();
        @(negedge clk);
        #1 rst_n = 1'b1;

        for (int i = 0; i <= MAX; i++) applyStimulus(1, i, 0, 0, 0);
        applyStimulus(1, 28, 0, 0, 0);
        applyStimulus(1, 29, 0, 0, 0);

        applyStimulus(0, 0, 0, 0, 0);
        for (int i = 5; i >= 0; i--) applyStimulus(1, i, 1, 0, 0);
        applyStimulus(1, 1, 0, 0, 0);
        applyStimulus(1, 2, 0, 0, 0);

        for (int i = 3; i <= 12; i++) applyStimulus(1, i, 0, 0, 0);
        applyStimulus(1, 17, 0, 0, 0);
        applyStimulus(1, 18, 0, 0, 0);
        applyStimulus(1, 19, 0, 0, 0);
        applyStimulus(1, 20, 0, 0, 1);

        applyStimulus(1, 40, 0, 0, 0);
        applyStimulus(1, 3, 0, 0, 0);
        applyStimulus(1, 4, 0, 0, 0);
        applyStimulus(1, 8, 0, 0, 0);
        applyStimulus(1, 9, 0, 0, 1);
        applyStimulus(1, 10, 0, 0, 0);
        applyStimulus(1, 11, 0, 0, 0);
        applyStimulus(1, 50, 0, 0, 0);
        applyStimulus(1, 60, 0, 0, 0);
        applyStimulus(1, 7, 0, 0, 1);
        applyStimulus(1, 8, 0, 0, 0);

        for (int i = 9; i <= 11; i++) applyStimulus(1, i, 0, 0, 0);
        applyStimulus(1, 12, 0, 1, 0);
        applyStimulus(1, 0, 0, 0, 0);
        applyStimulus(1, 1, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0);
        applyStimulus(1, 2, 0, 0, 0);
        applyStimulus(1, 3, 0, 0, 0);

        applyStimulus(1, 4, 0, 0, 0);
        applyStimulus(1, 20, 0, 0, 1);
        applyStimulus(1, 21, 0, 0, 0);
        doReset();

        applyStimulus(1, 10, 0, 0, 0);
        for (int i = 0; i < 260; i++) applyStimulus(1, 40, 0, 0, 0);
        applyStimulus(1, 5, 0, 0, 1);

        gen_q = 6;
        for (int i = 0; i < 3000; i++) begin
            r  = $urandom_range(0, 99);
            md = 1'($urandom_range(0, 1));
            cl = ($urandom_range(0, 19) == 0);
            if (r < 4) begin
                applyStimulus(0, $urandom_range(0, 255), md, 0, cl);
            end else if (r < 9) begin
                v = $urandom_range(0, 63);
                applyStimulus(1, v, md, 0, cl);
                gen_q = (v <= MAX) ? nextVal(v, md, 0) : $urandom_range(0, MAX);
            end else if (r < 10) begin
                doReset();
            end else begin
                cr = ($urandom_range(0, 9) == 0);
                applyStimulus(1, gen_q, md, cr, cl);
                gen_q = nextVal(gen_q, md, cr);
            end
        end

        @(negedge clk);
        #1;
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("[TB] FAIL drain: got %0d pending, expected 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
